// File: rtl/seven_seg_pkg.sv
// Shared constants, state type and segment encoder for the multiplexed 7-segment driver.
package seven_seg_pkg;

    localparam int SEG_W = 7;

    // Segment order is {a,b,c,d,e,f,g}, active-high.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    typedef enum logic {
        ST_IDLE,
        ST_CONV
    } scan_state_t;

    // Non-decimal codes render as blank rather than garbage.
    function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] code);
        if (code <= 4'd9) begin
            return SEG_DIGIT[code];
        end
        return SEG_BLANK;
    endfunction

endpackage

// File: rtl/seven_seg_bin2bcd.sv
// Sequential double-dabble: one add-3 + shift per cycle, BIN_W cycles per conversion.
module seven_seg_bin2bcd import seven_seg_pkg::*; #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    logic [BCD_W-1:0] w_src;
    logic [BCD_W-1:0] w_adj;
    logic [BCD_W-1:0] w_next;
    logic             w_bit;

    // The first step is taken on the start edge straight from the input value.
    assign w_src = r_busy ? r_bcd : '0;
    assign w_bit = r_busy ? r_bin[BIN_W-1] : bin[BIN_W-1];

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
        assign w_adj[4*gi +: 4] = (w_src[4*gi +: 4] >= 4'd5) ? (w_src[4*gi +: 4] + 4'd3)
                                                              :  w_src[4*gi +: 4];
    end

    assign w_next = {w_adj[BCD_W-2:0], w_bit};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (!r_busy) begin
            if (start) begin
                r_bcd  <= w_next;
                r_bin  <= bin << 1;
                r_cnt  <= CNT_W'(1);
                r_busy <= 1'b1;
            end
        end else if (r_cnt == CNT_W'(BIN_W)) begin
            r_busy <= 1'b0;
        end else begin
            r_bcd <= w_next;
            r_bin <= r_bin << 1;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign busy = r_busy;
    assign done = r_busy && (r_cnt == CNT_W'(BIN_W));
    assign bcd  = r_bcd;

endmodule

// File: rtl/seven_segment_scan.sv
// N-digit multiplexed 7-segment driver: load handshake, BCD conversion, digit scan.
// Define SEVEN_SEG_LZB_EN to blank leading zeros.
module seven_segment_scan import seven_seg_pkg::*; #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [BIN_W-1:0]      value,
    output logic                  ready,
    output logic                  overflow,
    output logic [SEG_W-1:0]      segments,
    output logic [NUM_DIGITS-1:0] digit_en
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(10 ** NUM_DIGITS - 1);

    scan_state_t r_state, w_state_next;

    logic                  r_overflow;
    logic                  r_dash;
    logic [BCD_W-1:0]      r_digits;
    logic [IDX_W-1:0]      r_idx;
    logic [DIV_W-1:0]      r_div;
    logic [SEG_W-1:0]      r_seg;
    logic [NUM_DIGITS-1:0] r_en;

    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_start;
    logic                  w_busy;
    logic                  w_done;
    logic [BCD_W-1:0]      w_bcd;
    logic [NUM_DIGITS-1:0] w_blank;
    logic [SEG_W-1:0]      w_seg [NUM_DIGITS];
    logic [SEG_W-1:0]      w_cur_seg;

    assign ready      = (r_state == ST_IDLE);
    assign w_accept   = load && ready;
    assign w_in_range = (value <= MAX_VAL);
    assign w_start    = w_accept && w_in_range;

    seven_seg_bin2bcd #(
        .NUM_DIGITS (NUM_DIGITS),
        .BIN_W      (BIN_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_start),
        .bin   (value),
        .busy  (w_busy),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start)          w_state_next = ST_CONV;
            ST_CONV: if (w_done || !w_busy) w_state_next = ST_IDLE;
            default:                       w_state_next = ST_IDLE;
        endcase
    end

    // Dashes persist until a later in-range conversion replaces the digit store.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_dash     <= 1'b0;
            r_digits   <= '0;
        end else begin
            if (w_accept) begin
                r_overflow <= !w_in_range;
                if (!w_in_range) begin
                    r_dash <= 1'b1;
                end
            end
            if (r_state == ST_CONV && w_done) begin
                r_digits <= w_bcd;
                r_dash   <= 1'b0;
            end
        end
    end

`ifdef SEVEN_SEG_LZB_EN
    logic w_hz;
    always_comb begin
        w_blank = '0;
        w_hz    = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_hz       = w_hz && (r_digits[4*i +: 4] == 4'd0);
            w_blank[i] = w_hz;
        end
    end
`else
    assign w_blank = '0;
`endif

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg
        assign w_seg[gi] = r_dash      ? SEG_DASH  :
                           w_blank[gi] ? SEG_BLANK : seg_encode(r_digits[4*gi +: 4]);
    end

    always_comb begin
        w_cur_seg = SEG_BLANK;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_cur_seg = w_seg[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= '0;
            r_seg <= '0;
            r_en  <= '0;
        end else begin
            r_en  <= NUM_DIGITS'(1) << r_idx;
            r_seg <= w_cur_seg;
            if (r_div == DIV_W'(SCAN_DIV - 1)) begin
                r_div <= '0;
                r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    assign overflow = r_overflow;
    assign segments = r_seg;
    assign digit_en = r_en;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Self-checking bench for seven_segment_scan: directed scenarios plus random loads vs. a decimal model.
module tb_seven_segment_scan;

    localparam int ND = 4;
    localparam int BW = 14;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [BW-1:0] value = '0;
    logic          ready, overflow;
    logic [6:0]    segments;
    logic [ND-1:0] digit_en;

    logic          load2 = 1'b0;
    logic [3:0]    value2 = '0;
    logic          ready2, overflow2;
    logic [6:0]    segments2;
    logic [0:0]    digit_en2;

    int checks_pass  = 0;
    int checks_total = 0;
    int cyc = 0;
    int disp_val = 0;
    bit disp_dash = 1'b0;

    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    seven_segment_scan #(.NUM_DIGITS(ND), .BIN_W(BW), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .ready(ready),
        .overflow(overflow), .segments(segments), .digit_en(digit_en)
    );

    seven_segment_scan #(.NUM_DIGITS(1), .BIN_W(4), .SCAN_DIV(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .load(load2), .value(value2), .ready(ready2),
        .overflow(overflow2), .segments(segments2), .digit_en(digit_en2)
    );

    always #5 clk = ~clk;

    // Count of clock edges since reset release; the scan position follows from it directly.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [6:0] exp_seg(input int v, input bit dash, input int idx);
        int p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
        if (dash) return 7'b0000001;
`ifdef SEVEN_SEG_LZB_EN
        if (idx > 0 && v < p) return 7'b0000000;
`endif
        return seg_tab[(v / p) % 10];
    endfunction

    task automatic scan_check(input int n);
        int idx;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            idx = ((cyc - 1) / SD) % ND;
            chk("digit_en", 32'(digit_en), 32'(1 << idx));
            chk("segments", 32'(segments), 32'(exp_seg(disp_val, disp_dash, idx)));
        end
    endtask

    task automatic do_load(input int v);
        @(negedge clk);
        load  = 1'b1;
        value = BW'(v);
        @(negedge clk);
        load = 1'b0;
        if (v > 9999) begin
            chk("ovf_ready", 32'(ready), 32'd1);
            chk("ovf_flag", 32'(overflow), 32'd1);
            disp_dash = 1'b1;
        end else begin
            chk("conv_ready", 32'(ready), 32'd0);
            chk("conv_ovf", 32'(overflow), 32'd0);
            repeat (13) begin
                @(negedge clk);
                chk("conv_busy", 32'(ready), 32'd0);
            end
            @(negedge clk);
            chk("conv_done", 32'(ready), 32'd1);
            disp_val  = v;
            disp_dash = 1'b0;
        end
        @(negedge clk);
        $display("load value=%0d overflow=%0b ready=%0b", v, overflow, ready);
        scan_check(2 * ND * SD);
    endtask

    initial begin
        int v;
        repeat (3) @(negedge clk);
        chk("rst_segments", 32'(segments), 32'd0);
        chk("rst_digit_en", 32'(digit_en), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // Idle scan after reset
        scan_check(32);
        $display("idle scan done");

        do_load(59);
        do_load(9999);
        do_load(10000);

        // Load while busy must be ignored
        @(negedge clk);
        load = 1'b1; value = BW'(1234);
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        load = 1'b1; value = BW'(42);
        @(negedge clk);
        load = 1'b0;
        chk("ignored_busy", 32'(ready), 32'd0);
        repeat (11) @(negedge clk);
        chk("ign_busy_end", 32'(ready), 32'd0);
        @(negedge clk);
        chk("ign_done", 32'(ready), 32'd1);
        disp_val = 1234; disp_dash = 1'b0;
        @(negedge clk);
        $display("load value=1234 then 42 while busy");
        scan_check(2 * ND * SD);

        // Reset in the middle of a conversion
        @(negedge clk);
        load = 1'b1; value = BW'(8888);
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_ovf", 32'(overflow), 32'd0);
        chk("abort_seg", 32'(segments), 32'd0);
        chk("abort_en", 32'(digit_en), 32'd0);
        rst_n = 1'b1;
        disp_val = 0; disp_dash = 1'b0;
        $display("reset during conversion of 8888");
        scan_check(40);

        // Random loads
        for (int i = 0; i < 10; i++) begin
            v = int'($urandom_range(0, 16383));
            do_load(v);
        end
        do_load(0);
        do_load(7);

        // Single-digit instance, scan every cycle
        @(negedge clk);
        chk("d1_en_idle", 32'(digit_en2), 32'd1);
        chk("d1_seg_idle", 32'(segments2), 32'(7'b1111110));
        load2 = 1'b1; value2 = 4'd9;
        @(negedge clk);
        load2 = 1'b0;
        chk("d1_busy0", 32'(ready2), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("d1_busy", 32'(ready2), 32'd0);
        end
        @(negedge clk);
        chk("d1_done", 32'(ready2), 32'd1);
        repeat (4) begin
            @(negedge clk);
            chk("d1_en", 32'(digit_en2), 32'd1);
            chk("d1_seg9", 32'(segments2), 32'(7'b1111011));
        end
        $display("single digit load value=9 segments=%b", segments2);
        load2 = 1'b1; value2 = 4'd12;
        @(negedge clk);
        load2 = 1'b0;
        chk("d1_ovf", 32'(overflow2), 32'd1);
        chk("d1_ovf_ready", 32'(ready2), 32'd1);
        @(negedge clk);
        chk("d1_dash", 32'(segments2), 32'(7'b0000001));
        $display("single digit load value=12 overflow=%0b", overflow2);

        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule
